// File: rtl/tile_seq_pkg.sv
// Shared types and defaults for the tile sequencer.
// State encoding is fixed at 3 bits so it can be probed from the datapath side.
package tile_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadW = 3'd1,
        StExec  = 3'd2,
        StAdd   = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_t;

    localparam int unsigned DefaultTimeout = 1023;

endpackage

// File: rtl/seq_watchdog.sv
// Per-state watchdog: counts cycles spent waiting for a phase to complete and
// flags expiry on the TIMEOUT-th enabled cycle since the last clear.
import tile_seq_pkg::*;

module seq_watchdog #(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CntW'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of completed wait cycles, so the current cycle is r_cnt+1.
    assign o_expire = i_enable && (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: LOAD_W -> EXEC -> ADD -> WRITE over a programmable tile count,
// with optional per-tile weight reload, per-channel adder tracking, watchdog and abort.
import tile_seq_pkg::*;

module tile_seq_ctrl #(
    parameter int unsigned TILE_W   = 8,
    parameter int unsigned N_ADDERS = 4,
    parameter int unsigned TIMEOUT  = DefaultTimeout
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [TILE_W-1:0]   num_tiles,
    input  logic                reload_weights,
    output logic                load_weight_en,
    input  logic                load_weight_done,
    output logic                exec_en,
    input  logic                load_data_exec_done,
    output logic [N_ADDERS-1:0] adder_en,
    input  logic [N_ADDERS-1:0] adder_done,
    output logic                write_en,
    input  logic                write_output_done,
    output logic [TILE_W-1:0]   tile_idx,
    output logic                is_last,
    output logic                busy,
    output logic                done,
    output logic                error
);

    state_t              r_state, w_state_d;
    logic [TILE_W-1:0]   r_tile, w_tile_d;
    logic [TILE_W-1:0]   r_last_idx, w_last_idx_d;
    logic                r_reload, w_reload_d;
    logic [N_ADDERS-1:0] r_mask, w_mask_d;

    logic                w_is_last;
    logic [N_ADDERS-1:0] w_mask_left;
    logic                w_wd_en;
    logic                w_wd_clear;
    logic                w_wd_expire;

    assign w_is_last   = (r_tile == r_last_idx);
    assign w_mask_left = r_mask & ~adder_done;
    assign w_wd_en     = (r_state == StLoadW) || (r_state == StExec) ||
                         (r_state == StAdd)   || (r_state == StWrite);
    assign w_wd_clear  = (w_state_d != r_state);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rstn     (rstn),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_en),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_state_d    = r_state;
        w_tile_d     = r_tile;
        w_last_idx_d = r_last_idx;
        w_reload_d   = r_reload;
        w_mask_d     = r_mask;
        if (abort) begin
            w_state_d = StIdle;
            w_tile_d  = '0;
            w_mask_d  = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        w_state_d    = StLoadW;
                        w_tile_d     = '0;
                        // A zero tile count runs a single tile.
                        w_last_idx_d = (num_tiles == '0) ? '0 : num_tiles - TILE_W'(1);
                        w_reload_d   = reload_weights;
                    end
                end
                StLoadW: begin
                    if (load_weight_done) begin
                        w_state_d = StExec;
                    end else if (w_wd_expire) begin
                        w_state_d = StErr;
                    end
                end
                StExec: begin
                    if (load_data_exec_done) begin
                        w_state_d = StAdd;
                        w_mask_d  = '1;
                    end else if (w_wd_expire) begin
                        w_state_d = StErr;
                    end
                end
                StAdd: begin
                    w_mask_d = w_mask_left;
                    if (w_mask_left == '0) begin
                        w_state_d = StWrite;
                    end else if (w_wd_expire) begin
                        w_state_d = StErr;
                        w_mask_d  = '0;
                    end
                end
                StWrite: begin
                    if (write_output_done) begin
                        if (w_is_last) begin
                            w_state_d = StDone;
                        end else begin
                            w_tile_d  = r_tile + TILE_W'(1);
                            w_state_d = r_reload ? StLoadW : StExec;
                        end
                    end else if (w_wd_expire) begin
                        w_state_d = StErr;
                    end
                end
                StDone: begin
                    w_state_d = StIdle;
                    w_tile_d  = '0;
                end
                StErr: begin
                    w_state_d = StErr;
                end
                default: begin
                    w_state_d = StIdle;
                    w_tile_d  = '0;
                    w_mask_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_tile     <= '0;
            r_last_idx <= '0;
            r_reload   <= 1'b0;
            r_mask     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_tile     <= w_tile_d;
            r_last_idx <= w_last_idx_d;
            r_reload   <= w_reload_d;
            r_mask     <= w_mask_d;
        end
    end

    always_comb begin
        load_weight_en = 1'b0;
        exec_en        = 1'b0;
        adder_en       = '0;
        write_en       = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        unique case (r_state)
            StLoadW: load_weight_en = 1'b1;
            StExec:  exec_en        = 1'b1;
            StAdd:   adder_en       = r_mask;
            StWrite: write_en       = 1'b1;
            StDone:  done           = 1'b1;
            StErr:   error          = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (r_state != StIdle);
    assign tile_idx = r_tile;
    // Gated so the idle/reset view shows is_last low even though the latched bound matches.
    assign is_last  = busy && w_is_last;

endmodule
